// File: rtl/rgb_pkg.sv
// Shared RGB frame definitions: pixel layout, channel offsets, FSM states.
// Used by the frame reader and the matching writer side.
package rgb_pkg;

  localparam int PIX_W         = 24;
  localparam int BYTES_PER_PIX = 3;
  localparam int OFF_R         = 0;
  localparam int OFF_G         = 1;
  localparam int OFF_B         = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD0,
    ST_RD1,
    ST_RD2,
    ST_LAST,
    ST_EMIT
  } rd_state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column raster position counter; inc advances one pixel, wraps at frame end.
// Ports: clk, rst_n, inc in; first (0,0), eol (last col), last (final pixel) out.
module raster_counter #(
  parameter int ROWS = 192,
  parameter int COLS = 192
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  output logic first,
  output logic eol,
  output logic last
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

  logic [RW-1:0] row_q;
  logic [CW-1:0] col_q;
  logic          row_end;

  assign eol     = (col_q == CW'(COLS - 1));
  assign row_end = (row_q == RW'(ROWS - 1));
  assign last    = eol && row_end;
  assign first   = (row_q == '0) && (col_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_q <= '0;
      col_q <= '0;
    end else if (inc) begin
      if (eol) begin
        col_q <= '0;
        row_q <= row_end ? '0 : row_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads one interleaved-RGB frame from byte RAM, streams 24-bit pixels.
// Ports: start/busy/done control, mem_rd/addr/rdata RAM, pix_* valid/ready stream.
module rgb_frame_reader
  import rgb_pkg::*;
#(
  parameter int ROWS   = 192,
  parameter int COLS   = 192,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              pix_eof
);

  rd_state_t         state_q;
  rd_state_t         state_d;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] base_inc;
  pix_t              pix_q;
  logic              done_q;
  logic              emit;
  logic              hs;
  logic              r_first;
  logic              r_eol;
  logic              r_last;

  assign emit     = (state_q == ST_EMIT);
  assign hs       = emit && pix_ready;
  assign base_inc = base_q + ADDR_W'(BYTES_PER_PIX);

  raster_counter #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hs),
    .first (r_first),
    .eol   (r_eol),
    .last  (r_last)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_RD0;
      ST_RD0:  state_d = ST_RD1;
      ST_RD1:  state_d = ST_RD2;
      ST_RD2:  state_d = ST_LAST;
      ST_LAST: state_d = ST_EMIT;
      ST_EMIT: begin
        if (pix_ready)
          state_d = r_last ? ST_IDLE : ST_RD0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= hs && r_last;
    end
  end

  // addr_q is loaded one cycle ahead so each RD state sees its own byte
  // address; it simply holds once the third read has been issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      addr_q <= '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE) && start: begin
          base_q <= '0;
          addr_q <= ADDR_W'(OFF_R);
        end
        state_q == ST_RD0:
          addr_q <= base_q + ADDR_W'(OFF_G);
        state_q == ST_RD1:
          addr_q <= base_q + ADDR_W'(OFF_B);
        hs && !r_last: begin
          base_q <= base_inc;
          addr_q <= base_inc;
        end
        hs && r_last:
          base_q <= '0;
        default: ;
      endcase
    end
  end

  // RAM data lags the strobe by one cycle: byte read in RDn lands in RDn+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= '0;
    end else begin
      unique case (state_q)
        ST_RD1:  pix_q.r <= mem_rdata;
        ST_RD2:  pix_q.g <= mem_rdata;
        ST_LAST: pix_q.b <= mem_rdata;
        default: ;
      endcase
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign mem_rd    = (state_q == ST_RD0) ||
                     (state_q == ST_RD1) ||
                     (state_q == ST_RD2);
  assign mem_addr  = addr_q;
  assign pix_valid = emit;
  assign pix_data  = pix_q;
  assign pix_sof   = emit && r_first;
  assign pix_eol   = emit && r_eol;
  assign pix_eof   = emit && r_last;

endmodule
